// File: rtl/pwm_pkg.sv
// Shared types and reset defaults for the complementary dead-time PWM.
package pwm_pkg;

  localparam int unsigned DEF_PERIOD = 25000000;
  localparam int unsigned DEF_DUTY   = 12500000;
  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic {IDLE, DEAD} state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// One complementary output pair: follows raw, inserts dt both-low cycles on every raw edge.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] dt,
  output logic            h,
  output logic            l
);

  state_t          state_q;
  logic [DT_W-1:0] dtc_q;
  logic            raw_q;
  logic            en_q;
  logic            h_q;
  logic            l_q;
  logic            trig;

  // The first enabled cycle is treated like a raw edge so a restart always begins dead.
  assign trig = (raw != raw_q) || !en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dtc_q   <= '0;
      raw_q   <= 1'b0;
      en_q    <= 1'b0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      raw_q <= raw;
      en_q  <= en;
      if (!en) begin
        state_q <= DEAD;
        dtc_q   <= '0;
        h_q     <= 1'b0;
        l_q     <= 1'b0;
      end else if (trig && dt != '0) begin
        state_q <= DEAD;
        dtc_q   <= dt;
        h_q     <= 1'b0;
        l_q     <= 1'b0;
      end else if (state_q == DEAD && !trig && dtc_q > DT_W'(1)) begin
        dtc_q <= dtc_q - DT_W'(1);
        h_q   <= 1'b0;
        l_q   <= 1'b0;
      end else begin
        state_q <= IDLE;
        dtc_q   <= '0;
        h_q     <= raw;
        l_q     <= !raw;
      end
    end
  end

  assign h = h_q;
  assign l = l_q;

endmodule

// File: rtl/pwm_comp_dt.sv
// N-channel complementary PWM: shared period counter, shadowed period/duty/dead-time,
// per-channel dead-time insertion.
module pwm_comp_dt #(
  parameter int unsigned CH         = 2,
  parameter int unsigned CW         = 27,
  parameter int unsigned DT_W       = 8,
  parameter int unsigned DEF_PERIOD = pwm_pkg::DEF_PERIOD,
  parameter int unsigned DEF_DUTY   = pwm_pkg::DEF_DUTY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CW-1:0]    period,
  input  logic [CH*CW-1:0] duty,
  input  logic [DT_W-1:0]  deadtime,
  input  logic             load,
  output logic             load_ack,
  output logic             cyc_start,
  output logic [CH-1:0]    pwm_h,
  output logic [CH-1:0]    pwm_l
);

  localparam logic [CW-1:0] PER_RST  = CW'(DEF_PERIOD);
  localparam logic [CW-1:0] DUTY_RST = CW'(DEF_DUTY);
  localparam logic [CW-1:0] PER_MIN  = CW'(pwm_pkg::MIN_PERIOD);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    per_sh_q, per_st_q;
  logic [CH*CW-1:0] duty_sh_q, duty_st_q;
  logic [DT_W-1:0]  dt_sh_q, dt_st_q;
  logic             pend_q;
  logic             load_ack_q;
  logic             cyc_start_q;
  logic [CW-1:0]    eff_per, last_cnt;
  logic             at_end, upd;
  logic [CH-1:0]    raw;

  always_comb begin
    eff_per  = (per_sh_q < PER_MIN) ? PER_MIN : per_sh_q;
    last_cnt = eff_per - CW'(1);
    at_end   = (cnt_q >= last_cnt);
    cnt_d    = (!en || at_end) ? '0 : cnt_q + CW'(1);
    // A load arriving on the boundary cycle is applied directly, bypassing staging.
    upd      = (pend_q || load) && (at_end || !en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      per_sh_q    <= PER_RST;
      duty_sh_q   <= {CH{DUTY_RST}};
      dt_sh_q     <= '0;
      per_st_q    <= '0;
      duty_st_q   <= '0;
      dt_st_q     <= '0;
      pend_q      <= 1'b0;
      load_ack_q  <= 1'b0;
      cyc_start_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      load_ack_q  <= upd;
      cyc_start_q <= en && (cnt_q == '0);
      if (load) begin
        per_st_q  <= period;
        duty_st_q <= duty;
        dt_st_q   <= deadtime;
      end
      if (upd) begin
        per_sh_q  <= load ? period   : per_st_q;
        duty_sh_q <= load ? duty     : duty_st_q;
        dt_sh_q   <= load ? deadtime : dt_st_q;
        pend_q    <= 1'b0;
      end else if (load) begin
        pend_q <= 1'b1;
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      raw[i] = (cnt_q < duty_sh_q[i*CW +: CW]);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pwm_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk(clk),
      .rst(rst),
      .en (en),
      .raw(raw[g]),
      .dt (dt_sh_q),
      .h  (pwm_h[g]),
      .l  (pwm_l[g])
    );
  end

  assign load_ack  = load_ack_q;
  assign cyc_start = cyc_start_q;

endmodule

// File: tb/tb_pwm_comp_dt.sv
// Scoreboard bench for pwm_comp_dt: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_pwm_comp_dt;

  localparam int unsigned CH   = 2;
  localparam int unsigned CW   = 8;
  localparam int unsigned DT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty;
  logic [DT_W-1:0]  deadtime;
  logic             load_ack;
  logic             cyc_start;
  logic [CH-1:0]    pwm_h;
  logic [CH-1:0]    pwm_l;

  pwm_comp_dt #(
    .CH(CH), .CW(CW), .DT_W(DT_W), .DEF_PERIOD(10), .DEF_DUTY(5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty),
    .deadtime(deadtime), .load(load), .load_ack(load_ack),
    .cyc_start(cyc_start), .pwm_h(pwm_h), .pwm_l(pwm_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            chk_hl;
    logic [CH-1:0] h;
    logic [CH-1:0] l;
    logic          cs;
  } exp_t;

  exp_t        exp_q[$];
  int          ack_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;

  int unsigned ecnt = 0;
  int unsigned P = 10;
  int unsigned T = 0;
  int unsigned D [CH] = '{5, 5};
  int unsigned nP = 0;
  int unsigned nT = 0;
  int unsigned nD [CH] = '{0, 0};
  int unsigned settle = 0;
  int          apply_cyc = -1;
  bit          pen = 1'b0;
  bit          ecs = 1'b0;

  exp_t        mon_e;
  logic        ack_exp;

  function automatic int unsigned effp(input int unsigned p);
    return (p < 2) ? 2 : p;
  endfunction

  // Steady-state {h,l} seen while the counter reads c: h over [t+1, d], l over [d+t+1, p-1] and 0.
  function automatic logic [1:0] hl(input int unsigned c, input int unsigned p,
                                    input int unsigned d, input int unsigned t);
    if (d == 0) return 2'b01;
    if (d >= p) return 2'b10;
    return {(c >= t + 1 && c <= d), (p - d > t) && (c == 0 || c >= d + t + 1)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("cyc_start", 32'(cyc_start), 32'(mon_e.cs));
      check("h_and_l", 32'(pwm_h & pwm_l), 32'd0);
      if (mon_e.chk_hl) begin
        check("pwm_h", 32'(pwm_h), 32'(mon_e.h));
        check("pwm_l", 32'(pwm_l), 32'(mon_e.l));
      end
    end
    ack_exp = (ack_q.size() > 0) && (ack_q[0] == cyc);
    check("load_ack", 32'(load_ack), 32'(ack_exp));
    if (ack_exp) void'(ack_q.pop_front());
  end

  task automatic step();
    exp_t        e;
    logic [1:0]  v;
    if (rst || !pen) settle = 0;
    e.cs     = ecs && !rst;
    e.chk_hl = 1'b1;
    e.h      = '0;
    e.l      = '0;
    if (!rst && pen) begin
      if (settle > 0) e.chk_hl = 1'b0;
      else begin
        for (int i = 0; i < CH; i++) begin
          v      = hl(ecnt, effp(P), D[i], T);
          e.h[i] = v[1];
          e.l[i] = v[0];
        end
      end
    end
    exp_q.push_back(e);
    if (settle > 0) settle--;
    if (rst) begin
      ecnt   = 0;
      pen    = 1'b0;
      ecs    = 1'b0;
      P      = 10;
      T      = 0;
      D      = '{5, 5};
      if (apply_cyc >= 0) begin
        void'(ack_q.pop_back());
        apply_cyc = -1;
      end
    end else begin
      if (load) begin
        nP = period;
        nT = deadtime;
        for (int i = 0; i < CH; i++) nD[i] = duty[i*CW +: CW];
        if (apply_cyc < 0) begin
          apply_cyc = en ? cyc + int'(effp(P) - ecnt) : cyc + 1;
          ack_q.push_back(apply_cyc);
        end
      end
      ecs = en && (ecnt == 0);
      pen = en;
      if (!en || ecnt >= effp(P) - 1) ecnt = 0;
      else ecnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == apply_cyc) begin
      P         = nP;
      T         = nT;
      D         = nD;
      settle    = effp(P);
      apply_cyc = -1;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_cnt(input int unsigned c);
    for (int k = 0; k < 300 && ecnt != c; k++) step();
  endtask

  task automatic do_load(input int unsigned p, input int unsigned d0,
                         input int unsigned d1, input int unsigned dt);
    period   = CW'(p);
    duty     = {CW'(d1), CW'(d0)};
    deadtime = DT_W'(dt);
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0;
    period = '0; duty = '0; deadtime = '0;
    @(posedge clk);
    #1;
    cyc = 0;
    run(3);
    // defaults, no dead-time
    rst = 1'b0; en = 1'b1;
    run(30);
    // new period/duty/dead-time loaded mid-period
    wait_cnt(4); do_load(20, 15, 7, 3); run(50);
    // high pulse narrower than dead-time
    wait_cnt(10); do_load(20, 2, 7, 3); run(45);
    // duty corners and period clamp
    wait_cnt(0); do_load(20, 0, 7, 3); run(45);
    do_load(20, 255, 7, 3); run(45);
    do_load(1, 1, 0, 0); run(20);
    do_load(10, 5, 3, 1); run(25);
    // double load before one boundary: only the second applies
    wait_cnt(2); do_load(16, 4, 4, 0);
    wait_cnt(6); do_load(12, 8, 2, 2);
    run(40);
    // load while disabled, then re-enable
    en = 1'b0; run(3);
    do_load(10, 5, 3, 2); run(3);
    en = 1'b1; run(30);
    // drop enable mid-period
    wait_cnt(7); en = 1'b0; step(); run(3);
    en = 1'b1; run(30);
    // reset mid-period with a load still pending
    wait_cnt(3); do_load(30, 10, 10, 0);
    rst = 1'b1; step(); step();
    rst = 1'b0; run(25);
    @(negedge clk);
    #1;
    check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
